// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline payload types, stage-register FSM states and width constants.
// Imported by pipe_stage_reg and its sub-modules.
package pipe_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
    } pipeline_reg_t;

    // Each load_* bit is routed by hazard glue to out_ready of the matching stage.
    typedef struct packed {
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
    } stall_load_reg_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_W = $bits(pipeline_reg_t);

    function automatic logic [1:0] pipe_occ(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with asynchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + ONE_INC;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer and flush.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_types::*;
#(
    parameter int WIDTH = PIPE_W,
    parameter int SKID  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    // Handshake: a payload moves across a port only on a rising edge where
    // that port's valid and ready are both 1; out_data is frozen while stalled.
    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = pipe_occ(main_valid, skid_valid);

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e      state;
            logic [WIDTH-1:0] skid_data;

            // Ready depends only on a flop, breaking the upstream ready path.
            assign in_ready = ~skid_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_data  <= '0;
                    skid_data  <= '0;
                end else if (flush_i) begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_xfer) begin
                                main_data  <= in_data;
                                main_valid <= 1'b1;
                                state      <= ONE;
                            end
                        end
                        ONE: begin
                            if (in_xfer && out_xfer) begin
                                main_data <= in_data;
                            end else if (in_xfer) begin
                                skid_data  <= in_data;
                                skid_valid <= 1'b1;
                                state      <= TWO;
                            end else if (out_xfer) begin
                                main_valid <= 1'b0;
                                state      <= EMPTY;
                            end
                        end
                        TWO: begin
                            // Skid entry is older than anything upstream, so it refills main.
                            if (out_xfer) begin
                                main_data  <= skid_data;
                                skid_valid <= 1'b0;
                                state      <= ONE;
                            end
                        end
                        default: begin
                            state      <= EMPTY;
                            main_valid <= 1'b0;
                            skid_valid <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready   = out_ready | ~main_valid;
            assign skid_valid = 1'b0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                end else if (flush_i) begin
                    main_valid <= 1'b0;
                end else if (in_xfer) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                end else if (out_xfer) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (main_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~main_valid),
        .cnt   (bubble_cnt)
    );
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!skid_valid || main_valid)
                else $error("skid entry valid while main entry empty");
            assert (CNT_W > 0)
                else $error("counter width must be positive");
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: skid (SKID=1) and combinational-ready (SKID=0) builds.
// Perf counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int W = 8;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];

    // SKID=1 instance
    logic         s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [W-1:0] s_in_data, s_out_data;
    logic [1:0]   s_occ;
    // SKID=0 instance
    logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [W-1:0] c_in_data, c_out_data;
    logic [1:0]   c_occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] s_stall_cnt, s_bubble_cnt, c_stall_cnt, c_bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .occupancy (s_occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (s_stall_cnt),
        .bubble_cnt (s_bubble_cnt)
`endif
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (c_flush),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_data  (c_out_data),
        .occupancy (c_occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (c_stall_cnt),
        .bubble_cnt (c_bubble_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0;
        c_flush = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
        step();
        step();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_out_valid got=%b exp=0", s_out_valid); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_in_ready got=%b exp=1", s_in_ready); end
        checks++; if (s_occ !== 2'd0) begin errors++; $display("FAIL reset_s_occ got=%0d exp=0", s_occ); end
        checks++; if (s_out_data !== 8'h00) begin errors++; $display("FAIL reset_s_out_data got=%h exp=00", s_out_data); end
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_c_out_valid got=%b exp=0", c_out_valid); end
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL reset_c_in_ready got=%b exp=1", c_in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [W-1:0] vals [3];
        logic [W-1:0] e;
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;
        exp_q.delete();
        s_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1; s_in_data = vals[i];
            exp_q.push_back(vals[i]);
            step();
            e = exp_q.pop_front();
            checks++; if (s_out_valid !== 1'b1 || s_out_data !== e) begin errors++; $display("FAIL stream_data got=%b/%h exp=1/%h", s_out_valid, s_out_data, e); end
            checks++; if (s_in_ready !== 1'b1 || s_occ !== 2'd1) begin errors++; $display("FAIL stream_ready_occ got=%b/%0d exp=1/1", s_in_ready, s_occ); end
        end
        s_in_valid = 0;
        step();
        checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin errors++; $display("FAIL stream_drain got=%b/%0d exp=0/0", s_out_valid, s_occ); end
    endtask

    task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = a; exp_q.push_back(a);
        step();
        s_in_data = b; exp_q.push_back(b);
        step();
        s_in_valid = 0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        exp_q.delete();
        fill_two(8'hB1, 8'hB2);
        checks++; if (s_occ !== 2'd2 || s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%0d/%b exp=2/0", s_occ, s_in_ready); end
        step();
        checks++; if (s_out_data !== 8'hB1 || s_occ !== 2'd2) begin errors++; $display("FAIL bp_hold got=%h/%0d exp=b1/2", s_out_data, s_occ); end
        s_out_ready = 1;
        #1;
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_before got=%b exp=0", s_in_ready); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if (s_out_valid !== 1'b1 || s_out_data !== e) begin errors++; $display("FAIL bp_order got=%b/%h exp=1/%h", s_out_valid, s_out_data, e); end
            step();
            checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b exp=1", s_in_ready); end
        end
        checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin errors++; $display("FAIL bp_empty got=%b/%0d exp=0/0", s_out_valid, s_occ); end
    endtask

    task automatic test_flush();
        exp_q.delete();
        fill_two(8'hB1, 8'hB2);
        s_in_valid = 1; s_in_data = 8'hC1; s_flush = 1;
        step();
        s_flush = 0; s_in_valid = 0;
        exp_q.delete();
        checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin errors++; $display("FAIL flush_two got=%b/%0d exp=0/0", s_out_valid, s_occ); end
        // flush from ONE while an input would otherwise be accepted
        s_out_ready = 0; s_in_valid = 1; s_in_data = 8'hD0;
        step();
        s_in_data = 8'hD1; s_flush = 1;
        step();
        s_flush = 0; s_in_valid = 0; s_out_ready = 1;
        checks++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL flush_one got=%b/%0d/%b exp=0/0/1", s_out_valid, s_occ, s_in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got=%b/%h exp=0", s_out_valid, s_out_data); end
        end
    endtask

    task automatic test_async_reset();
        exp_q.delete();
        fill_two(8'hE1, 8'hE2);
        checks++; if (s_occ !== 2'd2) begin errors++; $display("FAIL ares_pre got=%0d exp=2", s_occ); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_occ !== 2'd0) begin errors++; $display("FAIL ares_now got=%b/%b/%0d exp=0/1/0", s_out_valid, s_in_ready, s_occ); end
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        step();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        s_flush = 0; s_in_valid = 0; s_out_ready = 0;
        step();
        checks++; if (s_stall_cnt !== '0 || s_bubble_cnt !== '0) begin errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", s_stall_cnt, s_bubble_cnt); end
        rst_n = 1'b1;
        s_in_valid = 1; s_in_data = 8'hF1;
        step();
        s_in_valid = 0;
        repeat (5) step();
        s_out_ready = 1;
        step();
        repeat (3) step();
        checks++; if (s_stall_cnt !== 16'd5 || s_bubble_cnt !== 16'd4) begin errors++; $display("FAIL perf_counts got=%0d/%0d exp=5/4", s_stall_cnt, s_bubble_cnt); end
        s_out_ready = 0; s_in_valid = 1; s_in_data = 8'hF2;
        step();
        s_in_valid = 0; s_flush = 1;
        step();
        s_flush = 0; s_out_ready = 1;
        checks++; if (s_stall_cnt !== 16'd6 || s_bubble_cnt !== 16'd5) begin errors++; $display("FAIL perf_flush got=%0d/%0d exp=6/5", s_stall_cnt, s_bubble_cnt); end
    endtask
`endif

    task automatic test_comb_ready();
        exp_q.delete();
        c_out_ready = 0; c_in_valid = 1; c_in_data = 8'h5A;
        #1;
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL comb_empty_ready got=%b exp=1", c_in_ready); end
        exp_q.push_back(8'h5A);
        step();
        c_in_valid = 0;
        checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'h5A) begin errors++; $display("FAIL comb_load got=%b/%h exp=1/5a", c_out_valid, c_out_data); end
        #1;
        checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL comb_ready_low got=%b exp=0", c_in_ready); end
        c_out_ready = 1;
        #1;
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL comb_ready_high got=%b exp=1", c_in_ready); end
        c_out_ready = 0;
        #1;
        checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL comb_ready_relow got=%b exp=0", c_in_ready); end
    endtask

    task automatic test_comb_random();
        logic exp_ready, in_x, out_x;
        int   seen = 0;
        for (int i = 0; i < 100; i++) begin
            c_in_valid  = 1'($urandom_range(0, 1));
            c_in_data   = 8'($urandom_range(0, 255));
            c_out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = c_out_ready || (exp_q.size() == 0);
            checks++; if (c_in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, c_in_ready, exp_ready); end
            if (exp_q.size() != 0) begin
                checks++; if (c_out_valid !== 1'b1 || c_out_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%b/%h exp=1/%h", i, c_out_valid, c_out_data, exp_q[0]); end
            end else begin
                checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle cyc=%0d got=%b exp=0", i, c_out_valid); end
            end
            in_x  = c_in_valid && exp_ready;
            out_x = (exp_q.size() != 0) && c_out_ready;
            @(posedge clk);
            if (out_x) begin
                void'(exp_q.pop_front());
                seen++;
            end
            if (in_x) exp_q.push_back(c_in_data);
            #1;
        end
        c_in_valid = 0;
        checks++; if (seen == 0) begin errors++; $display("FAIL rnd_activity got=%0d exp>0", seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        test_comb_ready();
        test_comb_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
